// File: rtl/ans_judge.sv
// rtl/ans_judge.sv - factorization answer judge: serial prime-product check against the problem, saturating score.
// Optional macro JUDGE_ORDER_CHECK_EN additionally requires nondecreasing factors from the top slot down.
module ans_judge #(
  parameter int NSLOT   = 6,
  parameter int SCORE_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [11:0]          problem,
  input  logic [4*NSLOT-1:0]   answer,
  output logic                 busy,
  output logic                 done,
  output logic                 correct,
  output logic                 wrong,
  output logic [SCORE_W-1:0]   score
);

  localparam int ACC_W = 4 * NSLOT;
  localparam int IDX_W = $clog2(NSLOT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [11:0]          r_problem;
  logic [4*NSLOT-1:0]   r_answer;
  logic [ACC_W-1:0]     r_acc;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_invalid;
  logic                 r_nonempty;
  logic                 r_done;
  logic                 r_correct;
  logic                 r_wrong;
  logic [SCORE_W-1:0]   r_score;
`ifdef JUDGE_ORDER_CHECK_EN
  logic [3:0]           r_last;
`endif

  logic [3:0]           w_slot;
  logic                 w_prime;
  logic                 w_match;
  logic                 w_last_slot;

  always_comb begin
    w_slot = 4'd0;
    for (int i = 0; i < NSLOT; i++) begin
      if (r_idx == IDX_W'(i)) w_slot = r_answer[4*i +: 4];
    end
  end

  always_comb begin
    case (w_slot)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: w_prime = 1'b1;
      default:                              w_prime = 1'b0;
    endcase
  end

  assign w_last_slot = (r_idx == IDX_W'(NSLOT - 1));
  assign w_match     = r_nonempty & ~r_invalid &
                       (r_acc == {{(ACC_W-12){1'b0}}, r_problem});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_MUL;
      S_MUL:   if (w_last_slot) w_next = S_CMP;
      S_CMP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = r_done;
    correct = r_correct;
    wrong   = r_wrong;
    score   = r_score;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_problem  <= '0;
      r_answer   <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_invalid  <= 1'b0;
      r_nonempty <= 1'b0;
      r_done     <= 1'b0;
      r_correct  <= 1'b0;
      r_wrong    <= 1'b0;
      r_score    <= '0;
`ifdef JUDGE_ORDER_CHECK_EN
      r_last     <= 4'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_problem  <= problem;
            r_answer   <= answer;
            r_acc      <= ACC_W'(1);
            r_idx      <= '0;
            r_invalid  <= 1'b0;
            r_nonempty <= 1'b0;
            r_correct  <= 1'b0;
            r_wrong    <= 1'b0;
`ifdef JUDGE_ORDER_CHECK_EN
            r_last     <= 4'd0;
`endif
          end
        end
        S_MUL: begin
          // Non-prime slots still multiply; the invalid flag alone decides the verdict.
          if (w_slot != 4'd0) begin
            r_acc      <= r_acc * {{(ACC_W-4){1'b0}}, w_slot};
            r_nonempty <= 1'b1;
            if (!w_prime) r_invalid <= 1'b1;
`ifdef JUDGE_ORDER_CHECK_EN
            // Slots arrive low-to-high, so a higher slot may not exceed the previous factor.
            if (r_nonempty && (w_slot > r_last)) r_invalid <= 1'b1;
            r_last <= w_slot;
`endif
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        S_CMP: begin
          r_correct <= w_match;
          r_wrong   <= ~w_match;
          r_done    <= 1'b1;
          if (w_match && (r_score != {SCORE_W{1'b1}})) r_score <= r_score + SCORE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_judge.sv
// tb/tb_ans_judge.sv - directed self-checking bench for ans_judge (honours JUDGE_ORDER_CHECK_EN).
module tb_ans_judge;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [11:0] problem;
  logic [23:0] answer;
  logic        busy;
  logic        done;
  logic        correct;
  logic        wrong;
  logic [7:0]  score;

  int n_checks;
  int n_errors;
  int exp_score;

  ans_judge #(.NSLOT(6), .SCORE_W(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .problem (problem),
    .answer  (answer),
    .busy    (busy),
    .done    (done),
    .correct (correct),
    .wrong   (wrong),
    .score   (score)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one judgement and check latency, verdict, score and single-cycle done.
  task automatic judge(input string tag, input logic [11:0] p, input logic [23:0] a,
                       input bit repulse, input bit exp_ok);
    int lat;
    @(negedge CLK);
    problem = p;
    answer  = a;
    start   = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_clr"}, int'(correct | wrong), 0);
    problem = 12'hABC;
    answer  = 24'hFFFFFF;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK);
      #1;
      start = repulse && (k == 1 || k == 3);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    if (exp_ok && exp_score < 255) exp_score++;
    chk({tag, "_lat"}, lat, 7);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_correct"}, int'(correct), int'(exp_ok));
    chk({tag, "_wrong"}, int'(wrong), int'(!exp_ok));
    chk({tag, "_score"}, int'(score), exp_score);
    @(posedge CLK);
    #1;
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_hold"}, int'(correct), int'(exp_ok));
  endtask

  initial begin
    bit seen;
    n_checks  = 0;
    n_errors  = 0;
    exp_score = 0;
    RST     = 1'b1;
    start   = 1'b0;
    problem = 12'd0;
    answer  = 24'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_verdict", int'({correct, wrong}), 0);
    chk("rst_score", int'(score), 0);
    RST = 1'b0;

    judge("t36_ok", 12'd36, 24'h002233, 1'b0, 1'b1);
    judge("t36_one", 12'd36, 24'h000001, 1'b0, 1'b0);
`ifdef JUDGE_ORDER_CHECK_EN
    judge("t36_order", 12'd36, 24'h003322, 1'b0, 1'b0);
`else
    judge("t36_order", 12'd36, 24'h003322, 1'b0, 1'b1);
`endif
    judge("t30_repulse", 12'd30, 24'h000235, 1'b1, 1'b1);

    @(negedge CLK);
    problem = 12'd36;
    answer  = 24'h002233;
    start   = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outs", int'({done, correct, wrong}), 0);
    chk("abort_score", int'(score), 0);
    exp_score = 0;
    @(negedge CLK);
    RST  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_nodone", int'(seen), 0);

`ifdef JUDGE_ORDER_CHECK_EN
    judge("t4095", 12'd4095, 24'h0D7533, 1'b0, 1'b0);
`else
    judge("t4095", 12'd4095, 24'h0D7533, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 256; i++) judge("sat", 12'd36, 24'h002233, 1'b0, 1'b1);
    chk("sat_final", int'(score), 255);
    judge("empty", 12'd36, 24'h000000, 1'b0, 1'b0);
    judge("zero_prob", 12'd0, 24'h000000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ans_judge.md
Name: ans_judge

Overview:
- Judge at the far end of the answer path of the factorization game.
- Consumes the 24-bit answer word (six 4-bit factor slots) and the 12-bit problem number.
- Serially multiplies the prime factors and compares the product with the problem.
- Reports correct/wrong, and keeps a saturating score of correct answers for the display logic.

Parameters:
- NSLOT, 6, number of 4-bit factor slots in the answer word.
- SCORE_W, 8, width of the correct-answer score counter.

Ports:
- CLK  input  1  system clock, all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to judge the current problem/answer.
- problem  input  12  number to be factorized (unsigned).
- answer  input  24  factor slots; slot i = answer[4i+3:4i]; value 0 = empty slot.
- busy  output  1  high while a judgement is in progress.
- done  output  1  one-cycle pulse when correct/wrong become valid.
- correct  output  1  last judgement was correct; held until next accepted start.
- wrong  output  1  last judgement was wrong; held until next accepted start.
- score  output  SCORE_W  count of correct judgements since reset, saturating.

Behaviour:
- Reset (RST=1, asynchronous): state IDLE; busy, done, correct, wrong = 0; score = 0; internal accumulator, index and flags cleared. Reset mid-judgement aborts with no done pulse.
- States: IDLE, MUL, CMP.
- IDLE:
  - start=1 at edge N captures problem and answer into internal registers.
  - Sets acc=1, idx=0, invalid=0, nonempty=0.
  - Sets busy=1 and clears correct and wrong; goes to MUL.
  - start=0 keeps all outputs.
- MUL: edges N+1 to N+NSLOT each process slot idx (slot 0 first, LSB nibble), then idx increments.
  - Slot value 0: skipped; acc unchanged.
  - Slot value in {2,3,5,7,11,13}: acc = acc * value; nonempty=1.
  - Any other value (1,4,6,8,9,10,12,14,15): invalid=1, nonempty=1; acc still multiplied, result ignored.
  - acc is 24 bits; 15^6 < 2^24, so there is no overflow.
  - After slot NSLOT-1, go to CMP.
- CMP, edge N+NSLOT+1:
  - correct = nonempty & ~invalid & (acc == zero-extended problem); wrong = ~correct.
  - done=1 for exactly this one cycle; busy=0; back to IDLE.
  - score increments when correct=1 unless already all ones; it saturates and never wraps.
- Latency: done is asserted NSLOT+1 = 7 cycles after the edge that accepted start.
- start while busy=1 is ignored; no queueing. Changes on problem/answer after capture have no effect.
- start in the same cycle as done's return to IDLE is not accepted; it must arrive on or after the first IDLE cycle.
- correct and wrong are never both 1. Both are 0 after reset and during busy.
- All-empty answer (0x000000) → wrong.

Optional Feature:
- Macro JUDGE_ORDER_CHECK_EN.
- Defined:
  - Non-empty slots, read from slot NSLOT-1 down to slot 0, must be nondecreasing (e.g. 0x002233 = 2,2,3,3 is valid).
  - Any decrease sets invalid=1.
  - An order flag tracks the last non-empty value during MUL; latency is unchanged.
- Not defined: factor order is irrelevant; only primality and product matter.

Test Plan:
- Reset, then problem=36, answer=0x002233, start pulse → busy=1 for 7 cycles, then done pulse with correct=1, wrong=0, score=1.
- problem=36, answer=0x000001 → done after 7 cycles; wrong=1 (slot value 1 invalid); score unchanged.
- problem=36, answer=0x003322 → with JUDGE_ORDER_CHECK_EN: wrong=1; without it: correct=1.
- problem=30, answer=0x000235 with start re-pulsed at cycles 2 and 4 of busy → single done at cycle 7, correct=1; extra starts ignored.
- Assert RST at cycle 3 of a judgement (problem=36, answer=0x002233) → all outputs 0 immediately, no done. Then start problem=4095, answer=0x0D7533 (3·3·5·7·13) → correct=1.
- 256 consecutive correct judgements → score reaches 255 and stays at 255. Answer 0x000000 → wrong=1.
